// File: rtl/pgen_seq_pkg.sv
// Shared types and constants for the pgen_seq pulse-train sequencer.
// Holds the FSM state enum, register map addresses and reset defaults.
package pgen_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [3:0] ADDR_PERIOD     = 4'd0;
    localparam logic [3:0] ADDR_BURST      = 4'd1;
    localparam logic [3:0] ADDR_PHASE_BASE = 4'd2;
    localparam logic [3:0] ADDR_WIDTH_BASE = 4'd3;

    localparam int RST_PERIOD = 10;
    localparam int RST_BURST  = 0;
    localparam int RST_PHASE  = 0;
    localparam int RST_WIDTH  = 1;
    localparam int MIN_PERIOD = 2;

    function automatic logic [3:0] ph_addr(input int k);
        return ADDR_PHASE_BASE + 4'(2 * k);
    endfunction

    function automatic logic [3:0] wd_addr(input int k);
        return ADDR_WIDTH_BASE + 4'(2 * k);
    endfunction

endpackage

// File: rtl/pgen_seq_ch.sv
// One pulse channel: shadow/active PHASE and WIDTH, mod-PERIOD window
// compare and a registered pulse bit.
// Ports: clk, rst (async high); i_wr_phase/i_wr_width/i_wdata shadow
// writes; i_commit shadow->active; i_period/i_cnt timebase; i_en gate;
// o_pls registered pulse.
module pgen_seq_ch
    import pgen_seq_pkg::*;
#(
    parameter int P_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_phase,
    input  logic               i_wr_width,
    input  logic [P_CNT_W-1:0] i_wdata,
    input  logic               i_commit,
    input  logic [P_CNT_W-1:0] i_period,
    input  logic [P_CNT_W-1:0] i_cnt,
    input  logic               i_en,
    output logic               o_pls
);

    logic [P_CNT_W-1:0] r_sh_phase;
    logic [P_CNT_W-1:0] r_sh_width;
    logic [P_CNT_W-1:0] r_phase;
    logic [P_CNT_W-1:0] r_width;
    logic               r_pls;

    logic [P_CNT_W-1:0] w_phase_nx;
    logic [P_CNT_W-1:0] w_width_nx;
    logic [P_CNT_W-1:0] w_phase_mod;
    logic [P_CNT_W:0]   w_sum;
    logic [P_CNT_W:0]   w_diff;
    logic               w_hit;

    // A write in the commit cycle must be part of that commit.
    assign w_phase_nx = i_wr_phase ? i_wdata : r_sh_phase;
    assign w_width_nx = i_wr_width ? i_wdata : r_sh_width;

    // (cnt - phase) mod period, with cnt < period and phase reduced first,
    // so the sum lies in [1, 2*period) and needs at most one subtract.
    assign w_phase_mod = r_phase % i_period;
    assign w_sum = {1'b0, i_cnt} + {1'b0, i_period} - {1'b0, w_phase_mod};

    always_comb begin
        w_diff = w_sum;
        if (w_sum >= {1'b0, i_period}) begin
            w_diff = w_sum - {1'b0, i_period};
        end
    end

    assign w_hit = w_diff < {1'b0, r_width};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_phase <= P_CNT_W'(RST_PHASE);
            r_sh_width <= P_CNT_W'(RST_WIDTH);
            r_phase    <= P_CNT_W'(RST_PHASE);
            r_width    <= P_CNT_W'(RST_WIDTH);
            r_pls      <= 1'b0;
        end else begin
            r_sh_phase <= w_phase_nx;
            r_sh_width <= w_width_nx;
            if (i_commit) begin
                r_phase <= w_phase_nx;
                r_width <= w_width_nx;
            end
            r_pls <= i_en & w_hit;
        end
    end

    assign o_pls = r_pls;

endmodule

// File: rtl/pgen_seq.sv
// Multi-channel pulse-train sequencer: shared period timebase, burst or
// continuous runs, shadow config committed at period boundaries.
// Ports: clk, rst (async high), start, stop, sync_in, cfg_we/cfg_addr/
// cfg_wdata config writes; pls, sync_out, busy, done, period_idx outputs.
// Option: PGEN_SEQ_EXT_SYNC_EN adds an ARMED state waiting on sync_in.
module pgen_seq
    import pgen_seq_pkg::*;
#(
    parameter int P_NUM_CH  = 2,
    parameter int P_CNT_W   = 16,
    parameter int P_BURST_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sync_in,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [P_CNT_W-1:0]   cfg_wdata,
    output logic [P_NUM_CH-1:0]  pls,
    output logic                 sync_out,
    output logic                 busy,
    output logic                 done,
    output logic [P_BURST_W-1:0] period_idx
);

    localparam logic [P_CNT_W-1:0] L_MIN = P_CNT_W'(MIN_PERIOD);

    state_t               r_state;
    logic [P_CNT_W-1:0]   r_cnt;
    logic [P_CNT_W-1:0]   r_sh_period;
    logic [P_CNT_W-1:0]   r_period;
    logic [P_BURST_W-1:0] r_sh_burst;
    logic [P_BURST_W-1:0] r_burst;
    logic [P_BURST_W-1:0] r_pidx;
    logic                 r_sync_out;
    logic                 r_busy;
    logic                 r_done;

    logic [P_CNT_W-1:0]   w_period_nx;
    logic [P_BURST_W-1:0] w_burst_nx;
    logic                 w_wrap;
    logic                 w_last;
    logic                 w_go;
    logic                 w_commit;
    logic                 w_pls_en;
    logic                 w_sync_rise;

    assign w_period_nx = (cfg_we && cfg_addr == ADDR_PERIOD)
                       ? ((cfg_wdata < L_MIN) ? L_MIN : cfg_wdata)
                       : r_sh_period;
    assign w_burst_nx  = (cfg_we && cfg_addr == ADDR_BURST)
                       ? cfg_wdata[P_BURST_W-1:0]
                       : r_sh_burst;

    assign w_wrap = r_cnt == (r_period - P_CNT_W'(1));
    assign w_last = (r_burst != '0)
                 && (r_pidx == (r_burst - P_BURST_W'(1)));
    assign w_go   = (r_state == ST_IDLE) && start && !stop;

    assign w_commit = w_go || ((r_state == ST_RUN) && !stop && w_wrap);

    // Pulses are only produced for cycles that stay in RUN, so the
    // registered outputs are already low in the DONE/IDLE cycle.
    assign w_pls_en = (r_state == ST_RUN) && !stop && !(w_wrap && w_last);

`ifdef PGEN_SEQ_EXT_SYNC_EN
    logic r_sync_s1;
    logic r_sync_s2;
    logic r_sync_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_s1 <= 1'b0;
            r_sync_s2 <= 1'b0;
            r_sync_s3 <= 1'b0;
        end else begin
            r_sync_s1 <= sync_in;
            r_sync_s2 <= r_sync_s1;
            r_sync_s3 <= r_sync_s2;
        end
    end

    assign w_sync_rise = r_sync_s2 & ~r_sync_s3;
`else
    logic w_unused_sync;
    assign w_unused_sync = sync_in;
    assign w_sync_rise   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_period <= P_CNT_W'(RST_PERIOD);
            r_sh_burst  <= P_BURST_W'(RST_BURST);
            r_period    <= P_CNT_W'(RST_PERIOD);
            r_burst     <= P_BURST_W'(RST_BURST);
        end else begin
            r_sh_period <= w_period_nx;
            r_sh_burst  <= w_burst_nx;
            if (w_commit) begin
                r_period <= w_period_nx;
                r_burst  <= w_burst_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pidx     <= '0;
            r_sync_out <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sync_out <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_cnt  <= '0;
                        r_pidx <= '0;
                        r_busy <= 1'b1;
`ifdef PGEN_SEQ_EXT_SYNC_EN
                        r_state <= ST_ARMED;
`else
                        r_state <= ST_RUN;
`endif
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_sync_rise) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sync_out <= (r_cnt == '0);
                        if (w_wrap) begin
                            r_cnt <= '0;
                            if (w_last) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_pidx <= r_pidx + P_BURST_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + P_CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < P_NUM_CH; k++) begin : g_ch
        pgen_seq_ch #(
            .P_CNT_W(P_CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_wr_phase (cfg_we && (cfg_addr == ph_addr(k))),
            .i_wr_width (cfg_we && (cfg_addr == wd_addr(k))),
            .i_wdata    (cfg_wdata),
            .i_commit   (w_commit),
            .i_period   (r_period),
            .i_cnt      (r_cnt),
            .i_en       (w_pls_en),
            .o_pls      (pls[k])
        );
    end

    assign sync_out   = r_sync_out;
    assign busy       = r_busy;
    assign done       = r_done;
    assign period_idx = r_pidx;

endmodule

// File: tb/tb_pgen_seq.sv
// Self-checking bench for pgen_seq: vector table for the pulse window,
// scoreboard queue for per-cycle pls/sync_out, hand sequences for corners.
module tb_pgen_seq;

    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam int BW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic           sync_in;
    logic           cfg_we;
    logic [3:0]     cfg_addr;
    logic [CW-1:0]  cfg_wdata;
    logic [NCH-1:0] pls;
    logic           sync_out;
    logic           busy;
    logic           done;
    logic [BW-1:0]  period_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NCH-1:0] pls;
        logic           sync;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        int          wrp;
        int          eff;
        int          ph;
        int          wd;
        logic [15:0] mask;
    } vec_t;

    vec_t tv[8];

    always #5 clk = ~clk;

    pgen_seq #(
        .P_NUM_CH (NCH),
        .P_CNT_W  (CW),
        .P_BURST_W(BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .sync_in   (sync_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .pls       (pls),
        .sync_out  (sync_out),
        .busy      (busy),
        .done      (done),
        .period_idx(period_idx)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [CW-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic push(input logic [NCH-1:0] p, input logic s);
        exp_t e;
        e.pls  = p;
        e.sync = s;
        sbq.push_back(e);
    endtask

    task automatic step_cmp(input string name);
        exp_t e;
        step();
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sbq.pop_front();
            chk({name, "_pls"}, 32'(pls), 32'(e.pls));
            chk({name, "_sync"}, 32'(sync_out), 32'(e.sync));
        end
    endtask

    // Leaves the bench in the first RUN cycle (cnt==0).
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef PGEN_SEQ_EXT_SYNC_EN
        sync_in = 1'b1;
        step();
        step();
        step();
        sync_in = 1'b0;
`endif
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        logic s;
        logic [NCH-1:0] ep;
        logic [NCH-1:0] prev;
        int p0;
        int p1;

        tv[0] = '{10, 10, 8, 4, 16'h0303};
        tv[1] = '{10, 10, 0, 0, 16'h0000};
        tv[2] = '{10, 10, 0, 12, 16'h03FF};
        tv[3] = '{10, 10, 3, 2, 16'h0018};
        tv[4] = '{10, 10, 15, 2, 16'h0060};
        tv[5] = '{4, 4, 1, 1, 16'h0002};
        tv[6] = '{0, 2, 0, 1, 16'h0001};
        tv[7] = '{6, 6, 5, 3, 16'h0023};

        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        sync_in   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        step();
        step();
        chk("rst_pls", 32'(pls), 0);
        chk("rst_sync", 32'(sync_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pidx", 32'(period_idx), 0);
        rst = 1'b0;
        step();

        // Reset defaults: period 10, both channels phase 0 width 1.
        do_start();
        chk("def_busy", 32'(busy), 1);
        for (int n = 0; n < 20; n++) begin
            s = (n % 10) == 0;
            push({NCH{s}}, s);
            step_cmp("def");
        end
        do_stop();
        chk("def_stop_busy", 32'(busy), 0);
        step();

        // Window table on channel 0, channel 1 silenced.
        wr(4'd5, 16'd0);
        for (int i = 0; i < 8; i++) begin
            wr(4'd0, CW'(tv[i].wrp));
            wr(4'd2, CW'(tv[i].ph));
            wr(4'd3, CW'(tv[i].wd));
            do_start();
            for (int n = 0; n < 2 * tv[i].eff; n++) begin
                c = n % tv[i].eff;
                push({1'b0, tv[i].mask[c]}, c == 0);
                step_cmp($sformatf("win%0d_n%0d", i, n));
            end
            do_stop();
            step();
        end

        // Burst of 3 periods of 8.
        wr(4'd0, 16'd8);
        wr(4'd1, 16'd3);
        wr(4'd2, 16'd0);
        wr(4'd3, 16'd2);
        wr(4'd4, 16'd4);
        wr(4'd5, 16'd2);
        do_start();
        prev = '0;
        p0 = 0;
        p1 = 0;
        for (int n = 0; n < 24; n++) begin
            c = n % 8;
            if (n == 23) begin
                ep = '0;
                s  = 1'b0;
            end else begin
                ep = {(c == 4 || c == 5), (c < 2)};
                s  = (c == 0);
            end
            push(ep, s);
            step_cmp($sformatf("burst_n%0d", n));
            if (pls[0] && !prev[0]) p0++;
            if (pls[1] && !prev[1]) p1++;
            prev = pls;
            chk($sformatf("burst_done_n%0d", n), 32'(done), 32'(n == 23));
            chk($sformatf("burst_busy_n%0d", n), 32'(busy), 32'(n != 23));
        end
        chk("burst_p0", 32'(p0), 3);
        chk("burst_p1", 32'(p1), 3);
        chk("burst_pidx", 32'(period_idx), 2);
        step();
        chk("burst_done_off", 32'(done), 0);
        chk("burst_idle_busy", 32'(busy), 0);
        chk("burst_pidx_hold", 32'(period_idx), 2);
        wr(4'd1, 16'd0);

        // Live PERIOD change mid-period and on the wrap cycle.
        wr(4'd0, 16'd10);
        wr(4'd3, 16'd1);
        wr(4'd5, 16'd0);
        do_start();
        for (int n = 0; n < 36; n++) begin
            if (n == 3 || n == 27) begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'd0;
                cfg_wdata = (n == 3) ? 16'd6 : 16'd4;
            end else begin
                cfg_we = 1'b0;
            end
            s = (n == 0) || (n == 10) || (n == 16) || (n == 22)
             || (n == 28) || (n == 32);
            push({1'b0, s}, s);
            step_cmp($sformatf("live_n%0d", n));
        end
        cfg_we = 1'b0;
        do_stop();
        step();

        // Abort mid-pulse.
        wr(4'd0, 16'd10);
        wr(4'd3, 16'd4);
        do_start();
        step();
        step();
        chk("abort_pre_pls", 32'(pls[0]), 1);
        do_stop();
        chk("abort_pls", 32'(pls), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sync", 32'(sync_out), 0);
        chk("abort_pidx", 32'(period_idx), 0);

        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 32'(busy), 0);
        step();
        chk("ss_busy2", 32'(busy), 0);
        chk("ss_pls", 32'(pls), 0);

        // Asynchronous reset mid-run.
        wr(4'd3, 16'd12);
        do_start();
        step();
        step();
        step();
        chk("arst_pre_pls", 32'(pls[0]), 1);
        chk("arst_pre_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pls", 32'(pls), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sync", 32'(sync_out), 0);
        chk("arst_done", 32'(done), 0);
        step();
        rst = 1'b0;
        step();
        do_start();
        for (int n = 0; n < 12; n++) begin
            s = (n % 10) == 0;
            push({NCH{s}}, s);
            step_cmp("postrst");
        end
        do_stop();
        step();

`ifdef PGEN_SEQ_EXT_SYNC_EN
        start = 1'b1;
        step();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 1);
        for (int n = 0; n < 19; n++) step();
        chk("arm_wait_busy", 32'(busy), 1);
        chk("arm_wait_sync", 32'(sync_out), 0);
        chk("arm_wait_pls", 32'(pls), 0);
        sync_in = 1'b1;
        step();
        step();
        step();
        chk("arm_run_sync0", 32'(sync_out), 0);
        step();
        chk("arm_run_sync1", 32'(sync_out), 1);
        chk("arm_run_pls", 32'(pls), 3);
        sync_in = 1'b0;
        do_stop();
        chk("arm_stop_busy", 32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        do_stop();
        chk("arm_abort_busy", 32'(busy), 0);
        sync_in = 1'b1;
        for (int n = 0; n < 5; n++) step();
        sync_in = 1'b0;
        chk("arm_abort_idle", 32'(busy), 0);
        chk("arm_abort_sync", 32'(sync_out), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pgen_seq.md
Name: pgen_seq

Overview:
- Multi-channel pulse-train sequencer/controller for the pulse-generator fabric. Owns one shared period timebase; drives P_NUM_CH phase-offset, width-programmable pulse outputs.
- Runtime-configured through a simple register-write port, with shadow registers committed at period boundaries.
- Supports burst (N periods) and continuous modes, start/stop control, and a sync_out marker for chaining downstream generators.

Parameters:
- P_NUM_CH, 2, number of pulse channels (1..6).
- P_CNT_W, 16, width of period/phase/width registers and timebase counter.
- P_BURST_W, 8, width of burst-count register.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- stop  in  1  one-cycle abort; honoured in ARMED/RUN.
- sync_in  in  1  external sync; used only with the optional feature.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  4  register address.
- cfg_wdata  in  P_CNT_W  write data.
- pls  out  P_NUM_CH  pulse outputs, registered.
- sync_out  out  1  one-cycle marker at each period start, registered.
- busy  out  1  high in ARMED/RUN.
- done  out  1  one-cycle strobe at burst completion.
- period_idx  out  P_BURST_W  periods completed in current burst.

Behaviour:
- Reset: pls=0, sync_out=0, busy=0, done=0, period_idx=0, cnt=0, FSM=IDLE. Shadow and active registers: PERIOD=10, BURST=0, PHASE=0, WIDTH=1.
- Register map:
  - 0=PERIOD, in clocks; values <2 clamp to 2.
  - 1=BURST, low P_BURST_W bits; 0 = continuous.
  - 2+2k=PHASE[k]; 3+2k=WIDTH[k].
  - Unmapped addresses are ignored.
  - Writes always land in the shadow registers.
- Commit: shadow copies to active registers on the IDLE->RUN/ARMED transition and on every period wrap (cnt==PERIOD-1) in RUN. A write in the same cycle as a commit is included in that commit.
- FSM:
  - IDLE: start -> RUN, cnt=0, period_idx=0.
  - RUN: cnt increments each clock and wraps at PERIOD-1. At wrap, period_idx++. If BURST!=0 and period_idx==BURST-1 at wrap -> DONE.
  - DONE: lasts one cycle, done=1, then -> IDLE.
  - stop in ARMED/RUN -> IDLE next cycle. Pulses and sync_out are forced low from that cycle; period_idx holds.
  - Simultaneous start and stop: stop wins, so the block stays/returns to IDLE.
- Pulse rule: pls[k] is high the cycle after cnt satisfies ((cnt - PHASE[k]) mod PERIOD) < WIDTH[k], while in RUN.
  - One-cycle registered latency.
  - WIDTH=0 gives constant low; WIDTH>=PERIOD gives constant high.
  - PHASE>=PERIOD is reduced mod PERIOD by the same comparison.
- sync_out: high the cycle after cnt==0 in RUN.
- busy mirrors (state==ARMED || state==RUN), registered.
- pls and sync_out are low in IDLE/ARMED/DONE.
- Reset mid-run: immediate asynchronous return to the reset values above; the shadow configuration is lost.

Optional Feature:
- Macro PGEN_SEQ_EXT_SYNC_EN.
- Defined: start in IDLE -> ARMED. ARMED waits for a rising edge of sync_in, sampled through a 2-flop synchroniser plus edge detect, then -> RUN with cnt=0. busy=1 in ARMED.
- Undefined: ARMED is unreachable, sync_in is ignored, and start goes directly to RUN.

Decomposition:
- Package pgen_seq_pkg:
  - FSM state enum (IDLE, ARMED, RUN, DONE).
  - Register address constants (ADDR_PERIOD, ADDR_BURST, ADDR_PHASE_BASE, ADDR_WIDTH_BASE).
  - Reset-default constants.
- Sub-module pgen_seq_ch, instantiated P_NUM_CH times: holds the active PHASE/WIDTH for one channel, does the mod-PERIOD window compare, and registers one pls bit.

Test Plan:
- Reset defaults, start: PERIOD=10, PHASE0=0, WIDTH0=1, BURST=0 -> pls[0] high 1 clk in every 10; sync_out is coincident with pls[0]; busy=1.
- Burst: PERIOD=8, BURST=3, WIDTH0=2, PHASE1=4, WIDTH1=2 -> exactly 3 pulses on each channel, ch1 offset 4 clks from ch0; done pulses 1 clk after the 24th run cycle; busy falls; period_idx=2.
- Wrap window: PERIOD=10, PHASE0=8, WIDTH0=4 -> pls[0] high for cnt 8,9,0,1; also check WIDTH=0 (never high) and WIDTH=12 (always high).
- Live reconfig: during RUN, write PERIOD=6 mid-period -> current period completes at the old length, next period is 6 clks; a write coincident with wrap takes effect immediately.
- Abort: stop asserted mid-pulse -> pls=0 and busy=0 next cycle; start+stop together in IDLE -> stays IDLE; async rst mid-run -> all outputs 0 in the same cycle.
- With PGEN_SEQ_EXT_SYNC_EN: start, then sync_in rises 20 clks later -> RUN begins after synchroniser latency (3 clks), sync_out follows; stop in ARMED -> IDLE.
